// File: rtl/input_event_arbiter.sv
// Input event arbiter: collects one-cycle ticks from eight pad/button sources
// into a pending vector, offers them one at a time to a consumer with a
// valid/ready handshake in round-robin order, and enforces an idle cooldown
// after every accepted event. Merged ticks raise a sticky overflow flag.
module input_event_arbiter #(
    parameter int COOLDOWN = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] tick_in,
    input  logic [7:0] enable_mask,
    input  logic       evt_ready,
    input  logic       clr_overflow,
    output logic       evt_valid,
    output logic [2:0] evt_id,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam logic [7:0] CoolLoad = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        COOL
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       evt_valid_q, evt_valid_d;
    logic [2:0] evt_id_q, evt_id_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic       overflow_q, overflow_d;
    logic [7:0] cool_q, cool_d;

    logic       handshake;
    logic [7:0] hsVec;
    logic [7:0] acceptedTicks;
    logic [2:0] winner;
    logic       winnerFound;

    // Decode the handshake into a one-hot clear vector and mask incoming ticks
    always_comb begin
        handshake     = evt_valid_q & evt_ready;
        hsVec         = 8'h00;
        if (handshake) begin
            hsVec[evt_id_q] = 1'b1;
        end
        acceptedTicks = tick_in & enable_mask;
    end

    // Round-robin pick: first pending bit at or above rr_ptr, wrapping 7 -> 0
    always_comb begin
        logic [2:0] idx;
        idx         = 3'd0;
        winner      = rr_ptr_q;
        winnerFound = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = rr_ptr_q + 3'(k);
            if (!winnerFound && pending_q[idx]) begin
                winner      = idx;
                winnerFound = 1'b1;
            end
        end
    end

    // Pending bits clear on their handshake but a same-cycle tick re-arms them;
    // a tick landing on a still-pending, non-handshaking source is merged and
    // flagged, and a new merge beats a simultaneous clear request
    always_comb begin
        pending_d  = (pending_q & ~hsVec) | acceptedTicks;
        overflow_d = (|(acceptedTicks & pending_q & ~hsVec)) |
                     (overflow_q & ~clr_overflow);
    end

    // Offer sequencing: arbitrate in IDLE, hold the offer until accepted,
    // then sit out the cooldown before arbitrating again
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        cool_d      = cool_q;
        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    evt_id_d    = winner;
                    evt_valid_d = 1'b1;
                    state_d     = OFFER;
                end else begin
                    evt_valid_d = 1'b0;
                end
            end
            OFFER: begin
                if (handshake) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = evt_id_q + 3'd1;
                    if (CoolLoad != 8'd0) begin
                        cool_d  = CoolLoad;
                        state_d = COOL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            COOL: begin
                evt_valid_d = 1'b0;
                if (cool_q <= 8'd1) begin
                    cool_d  = 8'd0;
                    state_d = IDLE;
                end else begin
                    cool_d  = cool_q - 8'd1;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register; reset discards any offer and every pending event
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pending_q   <= 8'h00;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 3'd0;
            rr_ptr_q    <= 3'd0;
            overflow_q  <= 1'b0;
            cool_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            overflow_q  <= overflow_d;
            cool_q      <= cool_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
